pipelined_add_sub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor that splits a WIDTH-bit operation into STAGES equal chunks, one chunk per pipeline stage, with the inter-chunk carry registered between stages. Generalises the team's 8-bit ripple-carry full-adder chain:
- width and pipeline depth are parameters;
- adds subtract mode, signed-overflow and borrow reporting;
- adds a valid/ready handshake with backpressure.

It sits in datapaths that need a wide add at full clock rate with one result per cycle.

---
 rtl/pipelined_add_sub.sv | 162 ++++++++++++++++
 tb/tb_pipelined_add_sub.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit ripple-carry adder/subtractor split into STAGES
// equal chunks, one chunk per pipeline stage, with the inter-chunk carry
// registered between stages. Operands that have not yet been consumed travel
// forward in skew registers. Result chunks that are already complete travel
// forward in de-skew registers. A single global stall freezes every stage
// while the output beat is waiting on the consumer.
//
// Optional feature: define PIPELINED_ADD_SUB_SAT_EN to saturate sum on signed
// overflow. The saturation is applied in the final stage and adds no latency.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Per-stage pipeline state; index STAGES-1 is the output stage.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             sub_q   [STAGES];
  logic             sub_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];  // skew: operand A, upper chunks pending
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];  // skew: effective (possibly inverted) B
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];  // de-skew: completed lower result chunks
  logic [WIDTH-1:0] res_d   [STAGES];
  logic             co_q;
  logic             co_d;
  logic             ovf_q;
  logic             ovf_d;

  // Stage-input scratch values used while building each stage's next state.
  logic             stall;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_r;
  logic             src_c;
  logic             src_v;
  logic             src_sub;
  logic [CW:0]      chunk;
  logic             msb_cin;
`ifdef PIPELINED_ADD_SUB_SAT_EN
  logic             a_msb;
`endif

  // The pipe freezes only when the output beat is held by the consumer.
  assign stall     = valid_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign co        = co_q;
  assign ovf       = ovf_q;

  // Next state of every stage: one CW-bit chunk add per stage, plus the final flags.
  always_comb begin
    int prev;
    prev    = 0;
    src_a   = '0;
    src_b   = '0;
    src_r   = '0;
    src_c   = 1'b0;
    src_v   = 1'b0;
    src_sub = 1'b0;
    chunk   = '0;
    msb_cin = 1'b0;
`ifdef PIPELINED_ADD_SUB_SAT_EN
    a_msb   = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      prev = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Subtract is a + ~b + ~cin; the inversion is applied once at entry.
        src_a   = a;
        src_b   = sub ? ~b : b;
        src_c   = cin ^ sub;
        src_r   = '0;
        src_v   = in_valid;
        src_sub = sub;
      end else begin
        src_a   = a_q[prev];
        src_b   = b_q[prev];
        src_c   = carry_q[prev];
        src_r   = res_q[prev];
        src_v   = valid_q[prev];
        src_sub = sub_q[prev];
      end
      chunk = {1'b0, src_a[k*CW +: CW]} + {1'b0, src_b[k*CW +: CW]} + {{CW{1'b0}}, src_c};
      res_d[k]              = src_r;
      res_d[k][k*CW +: CW]  = chunk[CW-1:0];
      carry_d[k]            = chunk[CW];
      valid_d[k]            = src_v;
      sub_d[k]              = src_sub;
      a_d[k]                = src_a;
      b_d[k]                = src_b;
      if (k == STAGES - 1) begin
        // The carry into the MSB is recovered from the MSB's sum bit and its operands.
        msb_cin = chunk[CW-1] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1];
`ifdef PIPELINED_ADD_SUB_SAT_EN
        a_msb   = src_a[WIDTH-1];
`endif
      end else begin
        msb_cin = msb_cin;
      end
    end
    // In subtract mode the raw carry is an inverted borrow.
    co_d  = carry_d[STAGES-1] ^ sub_d[STAGES-1];
    ovf_d = msb_cin ^ carry_d[STAGES-1];
`ifdef PIPELINED_ADD_SUB_SAT_EN
    // On overflow, the sign of A gives the direction: positive overflow clamps to max, negative to min.
    if (ovf_d) begin
      res_d[STAGES-1] = {a_msb, {(WIDTH-1){~a_msb}}};
    end else begin
      res_d[STAGES-1] = res_d[STAGES-1];
    end
`endif
  end

  // Pipeline registers: clear on reset, hold on stall, otherwise advance one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sub_q[k]   <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        res_q[k]   <= '0;
      end
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        sub_q[k]   <= sub_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        res_q[k]   <= res_d[k];
      end
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=32, STAGES=4). Expected
// results are queued when a beat is accepted and compared when a result
// transfers out. Input handshakes are sampled on the falling edge, and new
// stimulus is applied 1 time unit after the rising edge.
module tb_pipelined_add_sub;

  localparam int W = 32;
  localparam int S = 4;

  typedef logic [W+1:0] exp_t;  // {ovf, co, sum}

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic acc;
  logic rand_ready = 1'b0;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model: plain wide arithmetic and operand-sign overflow rule.
  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fcin, input logic fsub);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    if (!fsub) begin
      full = {1'b0, fa} + {1'b0, fb} + {{W{1'b0}}, fcin};
      s = full[W-1:0];
      c = full[W];
      o = (fa[W-1] == fb[W-1]) && (s[W-1] != fa[W-1]);
    end else begin
      full = {1'b0, fa} - {1'b0, fb} - {{W{1'b0}}, fcin};
      s = full[W-1:0];
      c = full[W];
      o = (fa[W-1] != fb[W-1]) && (s[W-1] != fa[W-1]);
    end
`ifdef PIPELINED_ADD_SUB_SAT_EN
    if (o) s = fa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {o, c, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: scoreboard handshakes at negedge, then advance past posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("have_expected", {63'd0, sb_q.size() != 0}, 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sum", 64'(sum), 64'(e[W-1:0]));
          check("co",  64'(co),  64'(e[W]));
          check("ovf", 64'(ovf), 64'(e[W+1]));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(a, b, cin, sub));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tcin, input logic tsub);
    int n;
    a = ta; b = tb_v; cin = tcin; sub = tsub;
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc && n < 1000);
    check("accepted", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 500) begin
      step();
      n++;
    end
    check("drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    exp_t e1;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", 64'(co), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid_rel", 64'(out_valid), 64'd0);

    // Latency from acceptance to out_valid on an empty pipe.
    send_beat(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check("latency", 64'(cnt), 64'(S - 1));
    drain();

    // Directed corner cases, back-to-back.
    send_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send_beat(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send_beat(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send_beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send_beat(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    send_beat(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    drain();

    // Carry rippling across every stage, results on consecutive cycles.
    send_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send_beat(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check("b2b_first_sum", 64'(sum), 64'h0);
    check("b2b_first_co", 64'(co), 64'd1);
    step();
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_sum", 64'(sum), 64'h2345_6789);
    check("b2b_second_co", 64'(co), 64'd0);
    drain();

    // Backpressure: fill the pipe, hold for 5 cycles, then release.
    out_ready = 1'b0;
    e1 = model(32'h1000_0001, 32'h0F00_00FF, 1'b1, 1'b0);
    send_beat(32'h1000_0001, 32'h0F00_00FF, 1'b1, 1'b0);
    send_beat(32'h2222_2222, 32'h1111_1111, 1'b0, 1'b1);
    send_beat(32'h7000_0000, 32'h7000_0000, 1'b0, 1'b0);
    send_beat(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum_stable", 64'(sum), 64'(e1[W-1:0]));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_release_valid", 64'(out_valid), 64'd1);
      step();
    end
    check("bp_empty_valid", 64'(out_valid), 64'd0);
    check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset with beats in flight: outputs clear at once, old beats never emerge.
    out_ready = 1'b0;
    send_beat(32'hC000_0000, 32'h8000_0001, 1'b0, 1'b0);
    send_beat(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
    send_beat(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b1);
    step();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_co", 64'(co), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    send_beat(32'hABCD_0000, 32'h0000_1234, 1'b0, 1'b0);
    drain();

    // Random traffic with random gaps and backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
